// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Function : Runs the ST7920 init sequence, then shares the 8-bit parallel LCD
//            write port between two packet requesters (round-robin per packet).
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter #(
    parameter int EN_CYC   = 16,
    parameter int PWR_WAIT = 64,
    parameter int CLR_WAIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  rs_in,
    input  logic [15:0] dat_in,
    input  logic [1:0]  last_in,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic        init_done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_dat,
    output logic        lcd_psb,
    output logic        lcd_rst
);

    localparam int c_MAX_A = (EN_CYC > PWR_WAIT) ? EN_CYC : PWR_WAIT;
    localparam int c_MAX   = (c_MAX_A > CLR_WAIT) ? c_MAX_A : CLR_WAIT;
    localparam int c_CW    = $clog2(c_MAX + 1);

    localparam logic [c_CW-1:0] c_EN_LD  = c_CW'(EN_CYC - 1);
    localparam logic [c_CW-1:0] c_PWR_LD = c_CW'(PWR_WAIT - 1);
    localparam logic [c_CW-1:0] c_CLR_LD = c_CW'(CLR_WAIT - 1);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    typedef enum logic [2:0] {
        S_PWR       = 3'd0,
        S_INIT_LD   = 3'd1,
        S_ARB       = 3'd2,
        S_WAIT_BYTE = 3'd3,
        S_SETUP     = 3'd4,
        S_PULSE     = 3'd5,
        S_HOLD      = 3'd6,
        S_CLR       = 3'd7
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_init_idx;
    logic            r_init_done;
    logic [1:0]      r_gnt;
    logic            r_prio;
    logic            r_last;
    logic            r_rs;
    logic            r_en;
    logic [7:0]      r_dat;

    logic [7:0]      w_init_byte;
    logic [1:0]      w_ack;
    logic [1:0]      w_pick;
    logic            w_own;
    logic            w_cnt_zero;
    logic            w_is_clr;
    logic            w_byte_done;

    always_comb begin
        w_init_byte = 8'h30;
        case (r_init_idx)
            2'd0:    w_init_byte = 8'h30;
            2'd1:    w_init_byte = 8'h0C;
            2'd2:    w_init_byte = 8'h06;
            default: w_init_byte = 8'h01;
        endcase
    end

    // Gated by rst so an abandoned byte is never acknowledged.
    always_comb begin
        w_ack = 2'b00;
        if (r_state == S_WAIT_BYTE && !rst) begin
            w_ack = r_gnt & req;
        end
    end

    always_comb begin
        w_pick = req;
        if (req == 2'b11) begin
            w_pick = r_prio ? 2'b10 : 2'b01;
        end
    end

    assign w_own       = r_gnt[1];
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_is_clr    = !r_rs && (r_dat == 8'h01);
    assign w_byte_done = w_cnt_zero &&
                         ((r_state == S_HOLD && !w_is_clr) || r_state == S_CLR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_PWR;
            r_cnt       <= c_PWR_LD;
            r_init_idx  <= 2'd0;
            r_init_done <= 1'b0;
            r_gnt       <= 2'b00;
            r_prio      <= 1'b0;
            r_last      <= 1'b0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_dat       <= 8'h00;
        end else begin
            case (r_state)
                S_PWR: begin
                    if (w_cnt_zero) r_state <= S_INIT_LD;
                    else            r_cnt   <= r_cnt - c_ONE;
                end
                S_INIT_LD: begin
                    r_rs    <= 1'b0;
                    r_dat   <= w_init_byte;
                    r_last  <= 1'b0;
                    r_cnt   <= c_EN_LD;
                    r_state <= S_SETUP;
                end
                S_ARB: begin
                    if (r_init_done && req != 2'b00) begin
                        r_gnt   <= w_pick;
                        r_state <= S_WAIT_BYTE;
                    end
                end
                S_WAIT_BYTE: begin
                    if (w_ack != 2'b00) begin
                        r_rs    <= rs_in[w_own];
                        r_dat   <= w_own ? dat_in[15:8] : dat_in[7:0];
                        r_last  <= last_in[w_own];
                        r_cnt   <= c_EN_LD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b1;
                        r_cnt   <= c_EN_LD;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b0;
                        r_cnt   <= c_EN_LD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else if (w_is_clr) begin
                        r_cnt   <= c_CLR_LD;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - c_ONE;
                end
                default: r_state <= S_PWR;
            endcase

            // Common continuation once a byte (and any clear wait) is finished.
            if (w_byte_done) begin
                if (!r_init_done) begin
                    r_init_idx <= r_init_idx + 2'd1;
                    if (r_init_idx == 2'd3) begin
                        r_init_done <= 1'b1;
                        r_state     <= S_ARB;
                    end else begin
                        r_state <= S_INIT_LD;
                    end
                end else if (r_last) begin
                    r_gnt   <= 2'b00;
                    r_prio  <= ~w_own;
                    r_state <= S_ARB;
                end else begin
                    r_state <= S_WAIT_BYTE;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign ack       = w_ack;
    assign init_done = r_init_done;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = r_en;
    assign lcd_dat   = r_dat;
    assign lcd_psb   = 1'b1;
    assign lcd_rst   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Function : Self-checking bench for lcd_bus_arbiter (behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

    localparam int c_EN  = 4;
    localparam int c_PWR = 8;
    localparam int c_CLR = 20;
    localparam logic [7:0] c_INIT [4] = '{8'h30, 8'h0C, 8'h06, 8'h01};

    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
        logic       last;
    } bt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  rs_in = 2'b00;
    logic [15:0] dat_in = 16'h0000;
    logic [1:0]  last_in = 2'b00;
    logic [1:0]  gnt, ack;
    logic        init_done, lcd_rs, lcd_rw, lcd_en, lcd_psb, lcd_rst;
    logic [7:0]  lcd_dat;

    lcd_bus_arbiter #(.EN_CYC(c_EN), .PWR_WAIT(c_PWR), .CLR_WAIT(c_CLR)) u_dut (
        .clk(clk), .rst(rst), .req(req), .rs_in(rs_in), .dat_in(dat_in),
        .last_in(last_in), .gnt(gnt), .ack(ack), .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
        .lcd_psb(lcd_psb), .lcd_rst(lcd_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Requester packet queues and driver
    bt_t q0[$];
    bt_t q1[$];
    int  hold[2] = '{0, 0};
    bit  rnd_stall = 1'b0;

    task automatic push(input int who, input logic rs, input logic [7:0] d, input logic last);
        bt_t b;
        b.rs = rs; b.dat = d; b.last = last;
        if (who == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    initial begin : drv
        logic [1:0] a;
        bit         on;
        bt_t        b;
        forever begin
            @(negedge clk);
            a = ack;
            @(posedge clk); #1;
            if (a[0] && q0.size() > 0) void'(q0.pop_front());
            if (a[1] && q1.size() > 0) void'(q1.pop_front());
            for (int i = 0; i < 2; i++) begin
                on = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (hold[i] > 0) begin
                    hold[i]--;
                    on = 1'b0;
                end
                if (rnd_stall && $urandom_range(0, 3) == 0) on = 1'b0;
                if (on) begin
                    b = (i == 0) ? q0[0] : q1[0];
                end else begin
                    b.rs   = 1'($urandom_range(0, 1));
                    b.dat  = 8'($urandom);
                    b.last = 1'($urandom_range(0, 1));
                end
                req[i]            = on;
                rs_in[i]          = b.rs;
                dat_in[i*8 +: 8]  = b.dat;
                last_in[i]        = b.last;
            end
        end
    end

    // Behavioural model: a byte is an "age" window; outputs follow from age.
    localparam int M_GAP = 0, M_BYTE = 1, M_ARB = 2, M_WAIT = 3;
    int         m_mode, m_gap, m_age, m_src, m_owner, m_fav, m_init_cnt;
    bit         m_valid = 1'b0;
    bit         m_init_done, m_rs, m_last;
    logic [7:0] m_dat;

    initial begin : model
        logic [1:0] e_ack, e_gnt;
        logic       e_en;
        int         total;
        forever begin
            @(negedge clk);
            e_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
            e_ack = (m_mode == M_WAIT && !rst) ? (req & e_gnt) : 2'b00;
            e_en  = (m_mode == M_BYTE) && (m_age > c_EN) && (m_age <= 2*c_EN);
            if (m_valid) begin
                check("lcd_en",    32'(lcd_en),    32'(e_en));
                check("lcd_rs",    32'(lcd_rs),    32'(m_rs));
                check("lcd_dat",   32'(lcd_dat),   32'(m_dat));
                check("gnt",       32'(gnt),       32'(e_gnt));
                check("ack",       32'(ack),       32'(e_ack));
                check("init_done", 32'(init_done), 32'(m_init_done));
                check("lcd_const", 32'({lcd_rw, lcd_psb, lcd_rst}), 32'(3'b011));
            end
            if (rst) begin
                m_valid = 1'b1; m_mode = M_GAP; m_gap = c_PWR + 1;
                m_init_cnt = 0; m_init_done = 1'b0; m_owner = -1; m_fav = 0;
                m_rs = 1'b0; m_dat = 8'h00; m_last = 1'b0; m_age = 0; m_src = -1;
            end else if (m_valid) begin
                case (m_mode)
                    M_GAP: begin
                        if (m_gap > 1) m_gap--;
                        else begin
                            m_mode = M_BYTE; m_age = 1; m_src = -1;
                            m_rs = 1'b0; m_dat = c_INIT[m_init_cnt]; m_last = 1'b0;
                        end
                    end
                    M_ARB: begin
                        if (req != 2'b00) begin
                            m_owner = (req == 2'b11) ? m_fav : (req[1] ? 1 : 0);
                            m_mode  = M_WAIT;
                        end
                    end
                    M_WAIT: begin
                        if (req[m_owner]) begin
                            m_mode = M_BYTE; m_age = 1; m_src = m_owner;
                            m_rs   = rs_in[m_owner];
                            m_dat  = dat_in[m_owner*8 +: 8];
                            m_last = last_in[m_owner];
                        end
                    end
                    default: begin
                        total = 3*c_EN + ((!m_rs && m_dat == 8'h01) ? c_CLR : 0);
                        if (m_age < total) m_age++;
                        else if (m_src < 0) begin
                            m_init_cnt++;
                            if (m_init_cnt == 4) begin
                                m_init_done = 1'b1; m_mode = M_ARB;
                            end else begin
                                m_mode = M_GAP; m_gap = 1;
                            end
                        end else if (m_last) begin
                            m_fav = 1 - m_src; m_owner = -1; m_mode = M_ARB;
                        end else begin
                            m_mode = M_WAIT;
                        end
                    end
                endcase
            end
        end
    end

    // Event log used by the hand-computed timing checks
    int         cyc = 0, rst_cyc = 0;
    int         rise_t[$], fall_t[$], ack_t[$], ack_w[$], idone_t[$];
    logic [8:0] rise_b[$];
    logic       prev_en = 1'b0, prev_id = 1'b0;

    initial begin : mon
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) rst_cyc = cyc;
            if (lcd_en === 1'b1 && !prev_en) begin
                rise_t.push_back(cyc);
                rise_b.push_back({lcd_rs, lcd_dat});
            end
            if (lcd_en === 1'b0 && prev_en) fall_t.push_back(cyc);
            if (init_done === 1'b1 && !prev_id) idone_t.push_back(cyc);
            if (ack[0] === 1'b1) begin ack_t.push_back(cyc); ack_w.push_back(0); end
            if (ack[1] === 1'b1) begin ack_t.push_back(cyc); ack_w.push_back(1); end
            prev_en = (lcd_en === 1'b1);
            prev_id = (init_done === 1'b1);
        end
    end

    task automatic clr_log();
        rise_t.delete(); fall_t.delete(); ack_t.delete();
        ack_w.delete(); idone_t.delete(); rise_b.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && gnt == 2'b00) && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
        tick(2);
    endtask

    task automatic wait_init(input string name);
        int k;
        k = 0;
        while (init_done !== 1'b1 && k < 400) begin tick(1); k++; end
        check(name, 32'(k < 400), 32'd1);
    endtask

    initial begin : seq
        int       k, bad, src, idx;
        bt_t      b;
        // contention packets are queued while the DUT is still in reset/init
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 3; j++) begin
                push(0, 1'b1, 8'(8'hA0 + p*3 + j), j == 2);
                push(1, 1'b1, 8'(8'hB0 + p*3 + j), j == 2);
            end
        end
        @(negedge clk); @(negedge clk);
        check("rst_state", 32'({lcd_en, lcd_rs, lcd_dat, gnt, ack, init_done}), 32'd0);
        tick(2);
        rst = 1'b0;
        wait_init("init_timeout");
        wait_idle("contention_timeout", 1500);

        check("init_rises", 32'(rise_t.size() >= 16), 32'd1);
        check("first_en_rise", 32'(rise_t[0] - rst_cyc), 32'd14);
        for (int i = 0; i < 4; i++) begin
            check("init_byte", 32'(rise_b[i]), 32'({1'b0, c_INIT[i]}));
            check("init_en_width", 32'(fall_t[i] - rise_t[i]), 32'(c_EN));
            if (i > 0) check("init_spacing", 32'(rise_t[i] - rise_t[i-1]), 32'd13);
        end
        check("init_done_time", 32'(idone_t[0] - rst_cyc), 32'd81);
        check("first_ack_time", 32'(ack_t[0] - rst_cyc), 32'd82);
        check("cont_ack_count", 32'(ack_w.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            src = (i / 3) % 2;
            idx = (i / 6) * 3 + (i % 3);
            check("cont_ack_owner", 32'(ack_w[i]), 32'(src));
            check("cont_byte_order", 32'(rise_b[4+i]),
                  32'({1'b1, 8'((src != 0 ? 8'hB0 : 8'hA0) + idx)}));
        end

        // single packet from requester 0
        clr_log();
        push(0, 1'b1, 8'hD6, 1'b0);
        push(0, 1'b1, 8'hD0, 1'b1);
        wait_idle("single_timeout", 500);
        check("single_acks", 32'(ack_t.size()), 32'd2);
        check("single_owner", 32'({ack_w[0][0], ack_w[1][0]}), 32'd0);
        check("single_spacing", 32'(ack_t[1] - ack_t[0]), 32'd13);
        check("single_b0", 32'(rise_b[0]), 32'h1D6);
        check("single_b1", 32'(rise_b[1]), 32'h1D0);
        check("single_width", 32'(fall_t[1] - rise_t[1]), 32'(c_EN));

        // requester 0 stalls mid-packet while requester 1 waits
        clr_log();
        push(0, 1'b1, 8'hC0, 1'b0);
        push(0, 1'b1, 8'hC1, 1'b0);
        push(0, 1'b1, 8'hC2, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (ack[0] !== 1'b1 && k < 300);
        check("stall_first_ack", 32'(k < 300), 32'd1);
        hold[0] = 30;
        push(1, 1'b1, 8'hE0, 1'b0);
        push(1, 1'b1, 8'hE1, 1'b1);
        bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c >= 13 && (gnt !== 2'b01 || lcd_en !== 1'b0)) bad++;
        end
        check("stall_lock", 32'(bad), 32'd0);
        wait_idle("stall_timeout", 800);
        check("stall_acks", 32'(ack_w.size()), 32'd5);
        check("stall_owners", 32'({ack_w[0][0], ack_w[1][0], ack_w[2][0], ack_w[3][0], ack_w[4][0]}),
              32'(5'b00011));
        check("stall_gap", 32'(ack_t[1] - ack_t[0]), 32'd31);
        check("stall_b2", 32'(ack_t[2] - ack_t[1]), 32'd13);
        check("stall_handover", 32'(ack_t[3] - ack_t[2]), 32'd14);
        check("stall_r1", 32'(ack_t[4] - ack_t[3]), 32'd13);

        // clear command issued by a requester
        clr_log();
        push(0, 1'b0, 8'h01, 1'b0);
        push(0, 1'b1, 8'h41, 1'b1);
        wait_idle("clear_timeout", 500);
        check("clear_spacing", 32'(ack_t[1] - ack_t[0]), 32'd33);
        check("clear_bytes", 32'({rise_b[0], rise_b[1]}), 32'({9'h001, 9'h141}));

        // reset during the enable pulse
        push(0, 1'b1, 8'h55, 1'b0);
        push(0, 1'b1, 8'h56, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (lcd_en !== 1'b1 && k < 300);
        check("pulse_seen", 32'(k < 300), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clr_log();
        @(negedge clk);
        check("rst_pulse_state", 32'({lcd_en, gnt, ack, init_done}), 32'd0);
        wait_init("reinit_timeout");
        tick(2);
        check("reinit_rise", 32'(rise_t[0] - rst_cyc), 32'd14);
        check("reinit_byte", 32'(rise_b[0]), 32'h030);
        check("reinit_no_ack", 32'(ack_t.size()), 32'd0);

        // randomized traffic against the model
        rnd_stall = 1'b1;
        for (int p = 0; p < 30; p++) begin
            tick($urandom_range(0, 40));
            src = $urandom_range(0, 1);
            idx = $urandom_range(1, 3);
            for (int j = 0; j < idx; j++) begin
                if ($urandom_range(0, 7) == 0) begin
                    b.rs = 1'b0; b.dat = 8'h01;
                end else begin
                    b.rs = 1'($urandom_range(0, 1)); b.dat = 8'($urandom);
                end
                push(src, b.rs, b.dat, j == idx - 1);
            end
        end
        wait_idle("random_timeout", 8000);
        rnd_stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares one ST7920-style 8-bit parallel LCD write port (rs/rw/en/dat, psb=1 parallel mode) between two packet requesters, e.g. a text-line writer and a status-line writer.
- After reset it runs the LCD init sequence itself.
- It then grants the bus round-robin per packet and generates the enable-strobe timing for every byte, including the extended wait after a clear command.
- It sits between the requester logic and the LCD pins.

Parameters:
- EN_CYC, 16, clk cycles per timing phase (setup, en-high and hold each last EN_CYC cycles); must be ≥1.
- PWR_WAIT, 64, clk cycles of idle (en=0) after reset before the first init byte.
- CLR_WAIT, 256, extra clk cycles of idle after any command byte 0x01 (rs=0).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  2  req[i]: requester i has a byte valid on rs_in[i]/dat_in[i]/last_in[i].
- rs_in  in  2  per-requester register select (0 = command, 1 = data).
- dat_in  in  16  requester i byte on dat_in[8i+7:8i].
- last_in  in  2  marks the final byte of requester i's packet.
- gnt  out  2  one-hot, level; requester owning the bus for the current packet.
- ack  out  2  one-cycle pulse; the byte from requester i is consumed this cycle.
- init_done  out  1  high once the init sequence has completed.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD RW, constant 0.
- lcd_en  out  1  LCD E strobe.
- lcd_dat  out  8  LCD data bus.
- lcd_psb  out  1  constant 1 (parallel mode).
- lcd_rst  out  1  LCD reset, constant 1.

Behaviour:
- Reset (on any clk edge with rst=1, including mid-transfer):
  - state=PWR; lcd_en=0, lcd_rs=0, lcd_dat=0x00, gnt=00, ack=00, init_done=0.
  - Round-robin pointer favours requester 0 next.
  - Any in-flight byte is abandoned; no ack is issued for it.
- States: PWR, INIT_LD, ARB, WAIT_BYTE, SETUP, PULSE, HOLD, CLR.
- PWR: count PWR_WAIT cycles, then go to INIT_LD.
- INIT_LD: load the next init byte (rs=0) from the fixed list 0x30, 0x0C, 0x06, 0x01, then go to SETUP.
- Byte timing: all outputs are registered. lcd_rs/lcd_dat change only on entry to SETUP and are held stable through SETUP, PULSE and HOLD.
  - SETUP: EN_CYC cycles, lcd_en=0.
  - PULSE: EN_CYC cycles, lcd_en=1.
  - HOLD: EN_CYC cycles, lcd_en=0.
  - One byte therefore occupies exactly 3*EN_CYC cycles from SETUP entry to HOLD exit.
- After HOLD:
  - If the byte was rs=0, dat=0x01 (init or requester), go to CLR for CLR_WAIT cycles, en=0, then continue.
  - Otherwise continue immediately.
- Continue after an init byte: go to INIT_LD if list entries remain. After the 4th entry (0x01 + CLR) set init_done=1 and go to ARB.
- Continue after a requester byte:
  - If the byte had last=1: gnt←00, update the pointer to favour the other requester, go to ARB.
  - Else go to WAIT_BYTE, keeping gnt.
- ARB (1 cycle per decision):
  - If req=00, stay in ARB.
  - If exactly one bit is set, grant it.
  - If both are set, grant the favoured requester.
  - Register gnt one-hot, go to WAIT_BYTE. Requests are ignored before init_done.
- WAIT_BYTE:
  - ack[i] = gnt[i] & req[i] (combinational, this state only).
  - On ack, capture rs_in[i], dat_in[i] and last_in[i] and go to SETUP next cycle.
  - If req[i]=0, wait indefinitely and hold the grant (packet lock). The other requester cannot preempt mid-packet.
- Packet locking:
  - Bytes of one packet are never interleaved with the other requester.
  - A single-byte packet (last=1 on the first byte) releases the bus after that byte.
- Fairness: with both requesting continuously, packets alternate 0, 1, 0, 1, …
- Minimum per-byte cycle (no clear): WAIT_BYTE (1) + 3*EN_CYC.
- Inputs of the non-granted requester, and inputs of the granted requester outside WAIT_BYTE, are don't-care.

Test Plan:
- (EN_CYC=4, PWR_WAIT=8, CLR_WAIT=20 for all tests.)
- Reset then idle:
  - lcd_en stays 0 for 8 cycles.
  - lcd_dat/rs then step 0x30/0, 0x0C/0, 0x06/0, 0x01/0, each with en high for exactly 4 cycles, and 20 extra idle cycles after 0x01.
  - init_done rises after that; gnt stays 00 with req=00.
- Single packet, req0 only, bytes 0xD6 (rs=1), 0xD0 (rs=1, last=1):
  - gnt=01 one cycle after ARB; ack[0] pulses twice, 13 cycles apart.
  - lcd_dat=0xD6 then 0xD0, each with rs=1 and a 4-cycle en pulse.
  - gnt returns to 00.
- Contention: req=11 from init_done with 3-byte packets on both:
  - Bytes from requester 0 all precede any from requester 1.
  - Next round grants requester 1 first.
  - Neither requester's lcd_dat bytes are ever interleaved with the other's.
- Requester stall: req0 drops for 30 cycles mid-packet while req1 is high:
  - gnt remains 01 and lcd_en stays 0 during the stall.
  - Requester 1 is granted only after requester 0's last byte finishes HOLD.
- Clear via requester: a packet byte with rs=0, dat=0x01 is followed by 20 idle cycles before the next ack.
- Reset during PULSE: rst=1 while lcd_en=1 → lcd_en=0 on the next edge, gnt=00, no ack, init_done=0; the init sequence restarts from 0x30 after PWR_WAIT.
